// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the front-panel button conditioner: FSM states and
// default timing for the 50 MHz board clock.
package button_conditioner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEB_PRESS = 3'd1,
        ST_PRESSED   = 3'd2,
        ST_REPEAT    = 3'd3,
        ST_DEB_REL   = 3'd4
    } btn_state_e;

    localparam int DEF_CNT_W         = 20;
    localparam int DEF_DEB_CYCLES    = 50000;
    localparam int DEF_HOLD_CYCLES   = 1000000;
    localparam int DEF_REPEAT_CYCLES = 250000;

    // A cycle count must be at least 2 and must fit the shared counter.
    function automatic bit cycles_ok(longint value, int width);
        return (value >= 2) && (value <= ((longint'(1) << width) - 1));
    endfunction

endpackage

// File: rtl/button_conditioner_sync_2ff.sv
// Two-flop synchroniser for one asynchronous front-panel input.
module sync_2ff (
    input  logic CLK,
    input  logic BTNR,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge CLK or posedge BTNR) begin
        if (BTNR) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/button_conditioner.sv
// Debounced push-button with press/release pulses, long-press detection and
// an optional auto-repeat pulse stream.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | button released and stable
// DEB_PRESS  | counting consecutive high samples before accepting press
// PRESSED    | press accepted; timing toward long-press (frozen once held)
// REPEAT     | long press with auto-repeat stream running
// DEB_REL    | counting consecutive low samples before accepting release
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int CNT_W         = DEF_CNT_W,
    parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
    input  logic CLK,
    input  logic BTNR,
    input  logic BTN_IN,
    input  logic EN_REPEAT,
    output logic PRESS_P,
    output logic RELEASE_P,
    output logic REPEAT_P,
    output logic LEVEL,
    output logic HELD_LONG
);

    if (!cycles_ok(DEB_CYCLES, CNT_W)) begin : g_bad_deb
        $error("button_conditioner: DEB_CYCLES out of range for CNT_W");
    end
    if (!cycles_ok(HOLD_CYCLES, CNT_W)) begin : g_bad_hold
        $error("button_conditioner: HOLD_CYCLES out of range for CNT_W");
    end
    if (!cycles_ok(REPEAT_CYCLES, CNT_W)) begin : g_bad_rep
        $error("button_conditioner: REPEAT_CYCLES out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

    logic btn_s;

    sync_2ff u_sync (
        .CLK  (CLK),
        .BTNR (BTNR),
        .d    (BTN_IN),
        .q    (btn_s)
    );

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             rep_q, rep_d;
    logic             level_q, level_d;
    logic             held_q, held_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        rep_d   = 1'b0;
        level_d = level_q;
        held_d  = held_q;
        case (state_q)
            ST_IDLE: begin
                if (btn_s) begin
                    state_d = ST_DEB_PRESS;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_DEB_PRESS: begin
                if (!btn_s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                    level_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (!btn_s) begin
                    state_d = ST_DEB_REL;
                    cnt_d   = CNT_ONE;
                end else if (held_q) begin
                    // Held with repeat disabled: counter frozen until repeat is enabled.
                    if (EN_REPEAT) begin
                        state_d = ST_REPEAT;
                        cnt_d   = '0;
                    end
                end else if (cnt_q == HOLD_LAST) begin
                    held_d = 1'b1;
                    cnt_d  = '0;
                    if (EN_REPEAT) begin
                        state_d = ST_REPEAT;
                        rep_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_REPEAT: begin
                if (!btn_s) begin
                    state_d = ST_DEB_REL;
                    cnt_d   = CNT_ONE;
                end else if (cnt_q == REP_LAST) begin
                    rep_d = EN_REPEAT;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DEB_REL: begin
                if (btn_s) begin
                    state_d = held_q ? ST_REPEAT : ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_IDLE;
                    rel_d   = 1'b1;
                    level_d = 1'b0;
                    held_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge BTNR) begin
        if (BTNR) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            rep_q   <= 1'b0;
            level_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            rep_q   <= rep_d;
            level_q <= level_d;
            held_q  <= held_d;
        end
    end

    assign PRESS_P   = press_q;
    assign RELEASE_P = rel_q;
    assign REPEAT_P  = rep_q;
    assign LEVEL     = level_q;
    assign HELD_LONG = held_q;

endmodule
